crc8_stream_arbiter: RTL and testbench

Shares one CRC-8 engine (poly 0x07, init 0x00, no reflection, no final XOR, MSB byte first) between two packet requesters on the ualink_turbo64 datapath. Grants whole packets round-robin, accumulates a running CRC across 64-bit beats, and returns one 8-bit result per packet tagged with the requester id and beat count. Sits between the link-layer framers and the CRC insertion/check logic.

---
 rtl/crc8_stream_arbiter.sv | 160 ++++++++++++++++
 tb/tb_crc8_stream_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc8_stream_arbiter.sv
// crc8_stream_arbiter
//   Shares one CRC-8 engine (poly 0x07, init 0x00, MSB-first, no reflection,
//   no final XOR) between two packet requesters. Whole packets are granted
//   round-robin. A running CRC is accumulated across 64-bit beats. One result
//   per packet is returned, tagged with the owning requester and its beat count.
//
// Ports
//   axi_aclk, axi_resetn        clock, asynchronous active-low reset
//   reqN_valid/ready            beat handshake for requester N (N = 0, 1)
//   reqN_data[63:0]             beat payload, byte 0 in [63:56]
//   reqN_last, reqN_bytes[2:0]  end of packet, valid bytes on last beat (0 = 8)
//   res_valid/ready             result handshake
//   res_crc[7:0]                packet CRC
//   res_id                      requester that owned the packet
//   res_beats[CNT_W-1:0]        accepted beats in the packet (saturating)
module crc8_stream_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             axi_aclk,
  input  logic             axi_resetn,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [63:0]      req0_data,
  input  logic             req0_last,
  input  logic [2:0]       req0_bytes,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [63:0]      req1_data,
  input  logic             req1_last,
  input  logic [2:0]       req1_bytes,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_crc,
  output logic             res_id,
  output logic [CNT_W-1:0] res_beats
);

  typedef enum logic [1:0] {IDLE, BUSY, RESULT} state_t;

  state_t           state_q;
  logic             grant_q;
  logic             last_grant_q;
  logic [7:0]       crc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             req0_ready_q;
  logic             req1_ready_q;
  logic             res_valid_q;
  logic [7:0]       res_crc_q;
  logic             res_id_q;
  logic [CNT_W-1:0] res_beats_q;

  // Byte-serial CRC-8 over the first nbytes bytes of a beat, MSB byte first.
  function automatic logic [7:0] crc8_beat(input logic [7:0]  seed,
                                           input logic [63:0] data,
                                           input logic [3:0]  nbytes);
    logic [7:0] c;
    c = seed;
    for (int b = 0; b < 8; b++) begin
      if (4'(b) < nbytes) begin
        c = c ^ data[63 - 8*b -: 8];
        for (int k = 0; k < 8; k++) begin
          c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
      end
    end
    return c;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic             sel_valid;
  logic             sel_ready;
  logic [63:0]      sel_data;
  logic             sel_last;
  logic [2:0]       sel_bytes;
  logic [3:0]       eff_bytes;
  logic             beat_fire;
  logic             win_d;
  logic [7:0]       crc_d;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    sel_valid = grant_q ? req1_valid   : req0_valid;
    sel_ready = grant_q ? req1_ready_q : req0_ready_q;
    sel_data  = grant_q ? req1_data    : req0_data;
    sel_last  = grant_q ? req1_last    : req0_last;
    sel_bytes = grant_q ? req1_bytes   : req0_bytes;
    // Byte count only applies on the last beat; a count of 0 means a full beat.
    eff_bytes = (sel_last && (sel_bytes != 3'd0)) ? {1'b0, sel_bytes} : 4'd8;
    beat_fire = (state_q == BUSY) && sel_valid && sel_ready;
    // On a tie the requester that was not granted last wins.
    win_d     = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    crc_d     = crc8_beat(crc_q, sel_data, eff_bytes);
    cnt_d     = sat_inc(cnt_q);
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      crc_q        <= 8'h00;
      cnt_q        <= '0;
      req0_ready_q <= 1'b0;
      req1_ready_q <= 1'b0;
      res_valid_q  <= 1'b0;
      res_crc_q    <= 8'h00;
      res_id_q     <= 1'b0;
      res_beats_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            grant_q      <= win_d;
            crc_q        <= 8'h00;
            cnt_q        <= '0;
            req0_ready_q <= ~win_d;
            req1_ready_q <= win_d;
            state_q      <= BUSY;
          end
        end
        BUSY: begin
          // A dropped valid simply stalls here; the grant is never revoked.
          if (beat_fire) begin
            crc_q <= crc_d;
            cnt_q <= cnt_d;
            if (sel_last) begin
              state_q      <= RESULT;
              last_grant_q <= grant_q;
              req0_ready_q <= 1'b0;
              req1_ready_q <= 1'b0;
              res_valid_q  <= 1'b1;
              res_crc_q    <= crc_d;
              res_id_q     <= grant_q;
              res_beats_q  <= cnt_d;
            end
          end
        end
        RESULT: begin
          // Return to IDLE without arbitrating in the same cycle.
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req0_ready = req0_ready_q;
  assign req1_ready = req1_ready_q;
  assign res_valid  = res_valid_q;
  assign res_crc    = res_crc_q;
  assign res_id     = res_id_q;
  assign res_beats  = res_beats_q;

endmodule

// File: tb/tb_crc8_stream_arbiter.sv
// Directed bench for crc8_stream_arbiter: single and multi-beat packets,
// round-robin ties, result back-pressure, mid-packet valid gaps, reset in the
// middle of a packet and beat-count saturation.
module tb_crc8_stream_arbiter;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             axi_resetn;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [63:0]      req0_data, req1_data;
  logic             req0_last, req1_last;
  logic [2:0]       req0_bytes, req1_bytes;
  logic             res_valid, res_ready;
  logic [7:0]       res_crc;
  logic             res_id;
  logic [CNT_W-1:0] res_beats;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  crc8_stream_arbiter #(.CNT_W(CNT_W)) dut (
    .axi_aclk   (clk),
    .axi_resetn (axi_resetn),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_last  (req0_last),
    .req0_bytes (req0_bytes),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_last  (req1_last),
    .req1_bytes (req1_bytes),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_crc    (res_crc),
    .res_id     (res_id),
    .res_beats  (res_beats)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    req0_valid = 1'b0; req0_data = '0; req0_last = 1'b0; req0_bytes = '0;
    req1_valid = 1'b0; req1_data = '0; req1_last = 1'b0; req1_bytes = '0;
    res_ready  = 1'b0;
  endtask

  task automatic do_reset;
    clear_inputs();
    axi_resetn = 1'b0;
    tick();
    tick();
    axi_resetn = 1'b1;
    tick();
  endtask

  task automatic drive(input bit id, input logic [63:0] d, input logic l,
                       input logic [2:0] b, input logic v);
    if (id) begin
      req1_valid = v; req1_data = d; req1_last = l; req1_bytes = b;
    end else begin
      req0_valid = v; req0_data = d; req0_last = l; req0_bytes = b;
    end
  endtask

  // Presents one beat, waits (bounded) for ready, lets it be accepted, then
  // drops valid. Returns at one time step after the accepting edge.
  task automatic send_beat(input bit id, input logic [63:0] d, input logic l,
                           input logic [2:0] b, output bit ok);
    int n;
    drive(id, d, l, b, 1'b1);
    ok = 1'b1;
    n  = 0;
    while ((id ? req1_ready : req0_ready) !== 1'b1) begin
      tick();
      n++;
      if (n > 100) begin
        ok = 1'b0;
        break;
      end
    end
    tick();
    drive(id, d, l, b, 1'b0);
  endtask

  task automatic consume(output bit ok);
    int n;
    ok = 1'b1;
    n  = 0;
    while (res_valid !== 1'b1) begin
      tick();
      n++;
      if (n > 100) begin
        ok = 1'b0;
        break;
      end
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs();
    axi_resetn = 1'b1;
    #3;
    axi_resetn = 1'b0;
    #1;
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL rst_ready0 got %b want 0", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL rst_ready1 got %b want 0", req1_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid got %b want 0", res_valid); end
    checks++; if (res_crc !== 8'h00) begin errors++; $display("FAIL rst_res_crc got %h want 00", res_crc); end
    checks++; if (res_id !== 1'b0) begin errors++; $display("FAIL rst_res_id got %b want 0", res_id); end
    checks++; if (res_beats !== 16'h0000) begin errors++; $display("FAIL rst_res_beats got %h want 0000", res_beats); end
    tick();
    tick();
    axi_resetn = 1'b1;
    tick();
    tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_idle_res_valid got %b want 0", res_valid); end
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL rst_idle_ready0 got %b want 0", req0_ready); end
  endtask

  task automatic test_single;
    bit ok;
    do_reset();
    // Arbitration latency: valid seen in IDLE, ready one cycle later.
    drive(1'b0, 64'h0100_0000_0000_0000, 1'b1, 3'd1, 1'b1);
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL single_ready_early got %b want 0", req0_ready); end
    tick();
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready_arb got %b want 1", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready1 got %b want 0", req1_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_res_early got %b want 0", res_valid); end
    tick();
    drive(1'b0, '0, 1'b0, 3'd0, 1'b0);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL single_res_valid got %b want 1", res_valid); end
    checks++; if (res_crc !== 8'h07) begin errors++; $display("FAIL single_crc got %h want 07", res_crc); end
    checks++; if (res_id !== 1'b0) begin errors++; $display("FAIL single_id got %b want 0", res_id); end
    checks++; if (res_beats !== 16'd1) begin errors++; $display("FAIL single_beats got %0d want 1", res_beats); end
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL single_ready_after got %b want 0", req0_ready); end
    consume(ok);
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_res_drop got %b want 0", res_valid); end

    // Bytes past the count on the last beat are ignored.
    send_beat(1'b0, 64'h01AB_CDEF_1234_5678, 1'b1, 3'd1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tail_timeout got 0 want 1"); end
    checks++; if (res_crc !== 8'h07) begin errors++; $display("FAIL tail_crc got %h want 07", res_crc); end
    consume(ok);

    // Two bytes 01 01: 0x07 then table[0x06] = 0x12.
    send_beat(1'b0, 64'h0101_FFFF_FFFF_FFFF, 1'b1, 3'd2, ok);
    checks++; if (res_crc !== 8'h12) begin errors++; $display("FAIL two_byte_crc got %h want 12", res_crc); end
    consume(ok);
  endtask

  task automatic test_two_beat;
    bit ok;
    do_reset();
    send_beat(1'b1, 64'h3132_3334_3536_3738, 1'b0, 3'd0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL two_beat_timeout got 0 want 1"); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL two_beat_res_early got %b want 0", res_valid); end
    send_beat(1'b1, 64'h3900_0000_0000_0000, 1'b1, 3'd1, ok);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL two_beat_res_valid got %b want 1", res_valid); end
    checks++; if (res_crc !== 8'hF4) begin errors++; $display("FAIL two_beat_crc got %h want f4", res_crc); end
    checks++; if (res_id !== 1'b1) begin errors++; $display("FAIL two_beat_id got %b want 1", res_id); end
    checks++; if (res_beats !== 16'd2) begin errors++; $display("FAIL two_beat_beats got %0d want 2", res_beats); end
    consume(ok);
  endtask

  task automatic test_tie;
    bit ok;
    do_reset();
    drive(1'b0, '0, 1'b1, 3'd0, 1'b1);
    drive(1'b1, '0, 1'b1, 3'd0, 1'b1);
    tick();
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL tie1_ready0 got %b want 1", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL tie1_ready1 got %b want 0", req1_ready); end
    tick();
    req0_valid = 1'b0;
    checks++; if (res_crc !== 8'h00) begin errors++; $display("FAIL tie1_crc got %h want 00", res_crc); end
    checks++; if (res_id !== 1'b0) begin errors++; $display("FAIL tie1_id got %b want 0", res_id); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL tie1_ready1_result got %b want 0", req1_ready); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL tie2_ready1_idle got %b want 0", req1_ready); end
    tick();
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL tie2_ready1 got %b want 1", req1_ready); end
    tick();
    req1_valid = 1'b0;
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL tie2_res_valid got %b want 1", res_valid); end
    checks++; if (res_id !== 1'b1) begin errors++; $display("FAIL tie2_id got %b want 1", res_id); end
    checks++; if (res_beats !== 16'd1) begin errors++; $display("FAIL tie2_beats got %0d want 1", res_beats); end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    drive(1'b0, '0, 1'b1, 3'd0, 1'b1);
    drive(1'b1, '0, 1'b1, 3'd0, 1'b1);
    tick();
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL tie3_ready0 got %b want 1", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL tie3_ready1 got %b want 0", req1_ready); end
    tick();
    req0_valid = 1'b0;
    checks++; if (res_id !== 1'b0) begin errors++; $display("FAIL tie3_id got %b want 0", res_id); end
    consume(ok);
    send_beat(1'b1, '0, 1'b1, 3'd0, ok);
    checks++; if (res_id !== 1'b1) begin errors++; $display("FAIL tie4_id got %b want 1", res_id); end
    consume(ok);
  endtask

  task automatic test_backpressure;
    bit ok;
    do_reset();
    send_beat(1'b0, 64'h0100_0000_0000_0000, 1'b1, 3'd1, ok);
    drive(1'b1, '0, 1'b1, 3'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL bp_res_valid[%0d] got %b want 1", i, res_valid); end
      checks++; if (res_crc !== 8'h07) begin errors++; $display("FAIL bp_crc[%0d] got %h want 07", i, res_crc); end
      checks++; if (res_id !== 1'b0) begin errors++; $display("FAIL bp_id[%0d] got %b want 0", i, res_id); end
      checks++; if (res_beats !== 16'd1) begin errors++; $display("FAIL bp_beats[%0d] got %0d want 1", i, res_beats); end
      checks++; if ((req0_ready | req1_ready) !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got %b%b want 00", i, req0_ready, req1_ready); end
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL bp_ready1_t1 got %b want 0", req1_ready); end
    tick();
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1_t2 got %b want 1", req1_ready); end
    tick();
    req1_valid = 1'b0;
    checks++; if (res_id !== 1'b1) begin errors++; $display("FAIL bp_next_id got %b want 1", res_id); end
    consume(ok);
  endtask

  task automatic test_gaps;
    bit ok;
    do_reset();
    drive(1'b0, 64'h3132_3334_3536_3738, 1'b0, 3'd0, 1'b1);
    drive(1'b1, '0, 1'b1, 3'd0, 1'b1);
    tick();
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL gap_ready0 got %b want 1", req0_ready); end
    req0_valid = 1'b0;
    tick();
    tick();
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL gap_ready1_a got %b want 0", req1_ready); end
    req0_valid = 1'b1;
    tick();
    drive(1'b0, 64'h3900_0000_0000_0000, 1'b1, 3'd1, 1'b0);
    tick();
    tick();
    tick();
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL gap_ready1_b got %b want 0", req1_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL gap_res_early got %b want 0", res_valid); end
    req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL gap_res_valid got %b want 1", res_valid); end
    checks++; if (res_crc !== 8'hF4) begin errors++; $display("FAIL gap_crc got %h want f4", res_crc); end
    checks++; if (res_beats !== 16'd2) begin errors++; $display("FAIL gap_beats got %0d want 2", res_beats); end
    checks++; if (res_id !== 1'b0) begin errors++; $display("FAIL gap_id got %b want 0", res_id); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL gap_ready1_c got %b want 0", req1_ready); end
    consume(ok);
    send_beat(1'b1, '0, 1'b1, 3'd0, ok);
    checks++; if (res_id !== 1'b1) begin errors++; $display("FAIL gap_req1_id got %b want 1", res_id); end
    consume(ok);
  endtask

  task automatic test_midreset;
    bit ok;
    do_reset();
    for (int i = 0; i < 3; i++) send_beat(1'b0, 64'h1111_2222_3333_4444, 1'b0, 3'd0, ok);
    drive(1'b0, 64'h5555_6666_7777_8888, 1'b0, 3'd0, 1'b1);
    #2;
    axi_resetn = 1'b0;
    #1;
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL mr_ready0 got %b want 0", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL mr_ready1 got %b want 0", req1_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL mr_res_valid got %b want 0", res_valid); end
    checks++; if (res_beats !== 16'd0) begin errors++; $display("FAIL mr_res_beats got %0d want 0", res_beats); end
    clear_inputs();
    tick();
    tick();
    axi_resetn = 1'b1;
    tick();
    tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL mr_no_result got %b want 0", res_valid); end
    send_beat(1'b0, 64'h0100_0000_0000_0000, 1'b1, 3'd1, ok);
    checks++; if (res_crc !== 8'h07) begin errors++; $display("FAIL mr_crc got %h want 07", res_crc); end
    checks++; if (res_beats !== 16'd1) begin errors++; $display("FAIL mr_beats got %0d want 1", res_beats); end
    consume(ok);
  endtask

  task automatic test_saturate;
    bit ok;
    bit all_ok;
    do_reset();
    all_ok = 1'b1;
    for (int i = 0; i < 65539; i++) begin
      send_beat(1'b0, '0, 1'b0, 3'd0, ok);
      all_ok = all_ok & ok;
    end
    send_beat(1'b0, '0, 1'b1, 3'd0, ok);
    checks++; if (!all_ok) begin errors++; $display("FAIL sat_timeout got 0 want 1"); end
    checks++; if (res_beats !== 16'hFFFF) begin errors++; $display("FAIL sat_beats got %h want ffff", res_beats); end
    checks++; if (res_crc !== 8'h00) begin errors++; $display("FAIL sat_crc got %h want 00", res_crc); end
    consume(ok);
  endtask

  initial begin
    clear_inputs();
    axi_resetn = 1'b1;
    test_reset();
    test_single();
    test_two_beat();
    test_tie();
    test_backpressure();
    test_gaps();
    test_midreset();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
